// File: rtl/proj_001_pkg.sv
// Shared opcodes, state encoding and widths for the proj_001 two-operand calculator.
package proj_001_pkg;

    localparam int DW = 4;
    localparam int RW = 5;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_t;

endpackage

// File: rtl/proj_001_alu.sv
// Combinational 4-bit ALU producing a 5-bit unsigned result (add, modular subtract, and, xor).
module proj_001_alu
    import proj_001_pkg::*;
(
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] y
);

    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [DW-1:0] and_bits;
    logic [DW-1:0] xor_bits;

    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    for (genvar gi = 0; gi < DW; gi++) begin : g_bitwise
        assign and_bits[gi] = a[gi] & b[gi];
        assign xor_bits[gi] = a[gi] ^ b[gi];
    end

    // Subtraction wraps mod 32, so bit 4 doubles as the borrow flag.
    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a_ext + b_ext;
            OP_SUB:  y = a_ext - b_ext;
            OP_AND:  y = {1'b0, and_bits};
            OP_XOR:  y = {1'b0, xor_bits};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/proj_001.sv
// Two-operand serial calculator: operand A then operand B strobed by capture; registered result with one-cycle valid.
module proj_001
    import proj_001_pkg::*;
(
    input  logic          clock,
    input  logic          rst,
    input  logic          capture,
    input  logic [DW-1:0] d_in,
    input  logic [1:0]    op,
    output logic [RW-1:0] result,
    output logic          valid
);

    state_t        state_q, state_d;
    logic [DW-1:0] a_q, a_d;
    logic [RW-1:0] result_q, result_d;
    logic          valid_q, valid_d;
    logic [RW-1:0] alu_y;

    // Operand B goes straight from the input into the ALU; only A is stored.
    proj_001_alu u_alu (
        .op (op),
        .a  (a_q),
        .b  (d_in),
        .y  (alu_y)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (capture) begin
                    a_d     = d_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (capture) begin
                    result_d = alu_y;
                    valid_d  = 1'b1;
                    state_d  = WAIT_A;
                end
            end
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q  <= WAIT_A;
            a_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_proj_001.sv
// Self-checking bench for proj_001: expected results queued at B capture, popped when valid is observed.
module tb_proj_001;
    import proj_001_pkg::*;

    logic       clock = 1'b0;
    logic       rst;
    logic       capture;
    logic [3:0] d_in;
    logic [1:0] op;
    logic [4:0] result;
    logic       valid;

    int         assertions = 0;
    int         failures   = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_val;
    logic       valid_prev = 1'b0;

    always #5 clock = ~clock;

    proj_001 dut (
        .clock   (clock),
        .rst     (rst),
        .capture (capture),
        .d_in    (d_in),
        .op      (op),
        .result  (result),
        .valid   (valid)
    );

    // Independent reference: results computed in plain integer arithmetic.
    function automatic logic [4:0] ref_calc(input logic [1:0] o, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, r;
        ia = a;
        ib = b;
        case (o)
            2'b00:   r = ia + ib;
            2'b01:   r = (ia - ib + 32) % 32;
            2'b10:   r = ia & ib;
            default: r = ia ^ ib;
        endcase
        return 5'(r);
    endfunction

    task automatic step(input logic cap, input logic [3:0] d, input logic [1:0] o);
        capture = cap;
        d_in    = d;
        op      = o;
        @(posedge clock);
        #1;
        capture = 1'b0;
    endtask

    always @(negedge clock) begin
        if (rst !== 1'b1) begin
            assertions++;
            if (valid === 1'b1 && valid_prev === 1'b1) begin
                failures++;
                $display("FAIL valid_width: valid=1 for 2 consecutive cycles, required a single-cycle pulse");
            end
        end
        valid_prev = valid;
    end

    task automatic test_reset();
        rst = 1'b1; capture = 1'b1; d_in = 4'd7; op = OP_ADD;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock);
            #1;
            assertions++;
            if (result !== 5'd0 || valid !== 1'b0) begin
                failures++;
                $display("FAIL reset[%0d]: result=%0d valid=%b, required result=0 valid=0", i, result, valid);
            end
        end
        rst = 1'b0; capture = 1'b0;
        step(1'b1, 4'd4, OP_XOR);
        assertions++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_a: valid=%b, required 0", valid);
        end
        exp_q.push_back(5'd5);
        step(1'b1, 4'd1, OP_ADD);
        exp_val = exp_q.pop_front();
        assertions++;
        if (result !== exp_val || valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_pair: result=%0d valid=%b, required result=%0d valid=1", result, valid, exp_val);
        end
        $display("txn reset: 4 + 1 -> %0d", result);
        step(1'b0, 4'd0, OP_ADD);
    endtask

    // Directed table of pairs from the arithmetic and logic cases, each with a fixed expected value.
    task automatic test_ops();
        logic [3:0] ta [6] = '{4'd9,  4'd15, 4'd3,  4'd10, 4'd12, 4'd12};
        logic [3:0] tb [6] = '{4'd12, 4'd15, 4'd5,  4'd4,  4'd10, 4'd10};
        logic [1:0] to [6] = '{OP_ADD, OP_ADD, OP_SUB, OP_SUB, OP_AND, OP_XOR};
        logic [4:0] te [6] = '{5'd21, 5'd30, 5'd30, 5'd6,  5'd8,  5'd6};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, ta[i], ~to[i]);
            assertions++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL ops_a[%0d]: valid=%b, required 0", i, valid);
            end
            exp_q.push_back(te[i]);
            step(1'b1, tb[i], to[i]);
            exp_val = exp_q.pop_front();
            assertions++;
            if (result !== exp_val || valid !== 1'b1) begin
                failures++;
                $display("FAIL ops[%0d]: result=%0d valid=%b, required result=%0d valid=1", i, result, valid, exp_val);
            end
            $display("txn ops[%0d]: a=%0d b=%0d op=%0d -> %0d", i, ta[i], tb[i], to[i], result);
            step(1'b0, 4'd0, OP_ADD);
            assertions++;
            if (result !== exp_val || valid !== 1'b0) begin
                failures++;
                $display("FAIL ops_hold[%0d]: result=%0d valid=%b, required result=%0d valid=0", i, result, valid, exp_val);
            end
        end
    endtask

    task automatic test_gaps_hold();
        step(1'b1, 4'd2, OP_SUB);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'hF, OP_XOR);
            assertions++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL gap_idle[%0d]: valid=%b, required 0", i, valid);
            end
        end
        exp_q.push_back(5'd8);
        step(1'b1, 4'd6, OP_ADD);
        exp_val = exp_q.pop_front();
        assertions++;
        if (result !== exp_val || valid !== 1'b1) begin
            failures++;
            $display("FAIL gap_pair: result=%0d valid=%b, required result=%0d valid=1", result, valid, exp_val);
        end
        $display("txn gaps: 2 + 6 -> %0d", result);
        step(1'b0, 4'd0, OP_ADD);
        step(1'b1, 4'd3, OP_AND);
        for (int i = 0; i < 3; i++) begin
            assertions++;
            if (result !== 5'd8 || valid !== 1'b0) begin
                failures++;
                $display("FAIL hold[%0d]: result=%0d valid=%b, required result=8 valid=0", i, result, valid);
            end
            step(1'b0, 4'd0, OP_ADD);
        end
        exp_q.push_back(5'd3);
        step(1'b1, 4'd0, OP_ADD);
        exp_val = exp_q.pop_front();
        assertions++;
        if (result !== exp_val || valid !== 1'b1) begin
            failures++;
            $display("FAIL hold_close: result=%0d valid=%b, required result=%0d valid=1", result, valid, exp_val);
        end
        $display("txn hold: 3 + 0 -> %0d", result);
        step(1'b0, 4'd0, OP_ADD);
    endtask

    task automatic test_mid_reset();
        step(1'b1, 4'd5, OP_ADD);
        rst = 1'b1;
        @(posedge clock);
        #1;
        rst = 1'b0;
        assertions++;
        if (result !== 5'd0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: result=%0d valid=%b, required result=0 valid=0", result, valid);
        end
        step(1'b1, 4'd1, OP_SUB);
        assertions++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_a: valid=%b, required 0", valid);
        end
        exp_q.push_back(5'd2);
        step(1'b1, 4'd1, OP_ADD);
        exp_val = exp_q.pop_front();
        assertions++;
        if (result !== exp_val || valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_pair: result=%0d valid=%b, required result=%0d valid=1", result, valid, exp_val);
        end
        $display("txn mid_reset: 1 + 1 -> %0d", result);
        step(1'b0, 4'd0, OP_ADD);
    endtask

    // Capture held high every cycle: results must arrive exactly every second edge.
    task automatic test_back_to_back();
        logic [3:0] a, b;
        logic [1:0] o;
        capture = 1'b1;
        for (int i = 0; i < 12; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            d_in = a; op = ~o;
            @(posedge clock);
            #1;
            assertions++;
            if (valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_a[%0d]: valid=%b, required 0", i, valid);
            end
            exp_q.push_back(ref_calc(o, a, b));
            d_in = b; op = o;
            @(posedge clock);
            #1;
            exp_val = exp_q.pop_front();
            assertions++;
            if (result !== exp_val || valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b[%0d]: result=%0d valid=%b, required result=%0d valid=1", i, result, valid, exp_val);
            end
            $display("txn b2b[%0d]: a=%0d b=%0d op=%0d -> %0d", i, a, b, o, result);
        end
        capture = 1'b0;
        step(1'b0, 4'd0, OP_ADD);
    endtask

    initial begin
        rst = 1'b0; capture = 1'b0; d_in = '0; op = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_ops();
        test_gaps_hold();
        test_mid_reset();
        test_back_to_back();
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
